// File: rtl/trap_csr_sequencer_pkg.sv
// Shared definitions for the trap/MRET sequencer: CSR addresses, mstatus bit positions,
// privilege encodings and the sequencer state type.
package trap_csr_sequencer_pkg;

   localparam int XLEN_DEF   = 64;
   localparam int CSR_AW_DEF = 12;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      T_EPC,
      T_CAUSE,
      T_TVAL,
      T_STAT,
      M_STAT,
      REDIR
   } state_t;

endpackage

// File: rtl/trap_csr_sequencer_if.sv
// Request/response bundle between writeback/trap handler, the sequencer and the CSR file.
// The sequencer connects through the slave modport; the pipeline side uses master.
interface trap_csr_sequencer_if #(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 12
);
   logic              TRAP_REQ;
   logic [XLEN-1:0]   TRAP_CAUSE;
   logic [XLEN-1:0]   TRAP_EPC;
   logic [XLEN-1:0]   TRAP_TVAL;
   logic              MRET_REQ;
   logic              CSR_INSN_WE;
   logic [CSR_AW-1:0] CSR_INSN_ADDR;
   logic [XLEN-1:0]   CSR_INSN_DATA;
   logic [XLEN-1:0]   MTVEC;
   logic [XLEN-1:0]   MEPC;
   logic [XLEN-1:0]   MSTATUS;
   logic              CSR_WE;
   logic [CSR_AW-1:0] CSR_WADDR;
   logic [XLEN-1:0]   CSR_WDATA;
   logic              FLUSH;
   logic              REDIRECT_V;
   logic [XLEN-1:0]   REDIRECT_PC;
   logic [1:0]        PRIV;
   logic              BUSY;

   modport master (
      output TRAP_REQ, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, MRET_REQ,
             CSR_INSN_WE, CSR_INSN_ADDR, CSR_INSN_DATA, MTVEC, MEPC, MSTATUS,
      input  CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, REDIRECT_V, REDIRECT_PC, PRIV, BUSY
   );

   modport slave (
      input  TRAP_REQ, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, MRET_REQ,
             CSR_INSN_WE, CSR_INSN_ADDR, CSR_INSN_DATA, MTVEC, MEPC, MSTATUS,
      output CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, REDIRECT_V, REDIRECT_PC, PRIV, BUSY
   );

endinterface

// File: rtl/trap_csr_sequencer_target.sv
// trap_target_calc: combinational trap redirect target from mtvec and the latched cause.
// Build option TRAP_VECTORED_EN: interrupts with mtvec mode 01 jump to base + 4*cause[5:0].
module trap_target_calc
   import trap_csr_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] i_mtvec,
   input  logic [XLEN-1:0] i_cause,
   output logic [XLEN-1:0] o_pc
);
   logic [XLEN-1:0] w_base;
   logic            w_unused;

   assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   assign w_unused = ^i_cause[XLEN-2:6];

   always_comb begin
      // NOTE: default assignment first, so every path drives o_pc and no latch is inferred.
      o_pc = w_base;
      if (i_mtvec[1:0] == 2'b01 && i_cause[XLEN-1])
         o_pc = w_base + {{(XLEN-8){1'b0}}, i_cause[5:0], 2'b00};
   end
`else
   // Mode bits and cause do not affect the target in the direct-only build.
   assign w_unused = ^{i_cause, i_mtvec[1:0]};
   assign o_pc     = w_base;
`endif

endmodule

// File: rtl/trap_csr_sequencer.sv
// trap_csr_sequencer: sequences trap entry and MRET, owning the single CSR-file write port.
// Build option TRAP_VECTORED_EN enables vectored interrupt targets inside trap_target_calc.
module trap_csr_sequencer
   import trap_csr_sequencer_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int CSR_AW = CSR_AW_DEF
) (
   input  logic                CLK,
   input  logic                RESET,
   trap_csr_sequencer_if.slave bus
);
   state_t            r_state;
   logic              r_csr_we;
   logic [CSR_AW-1:0] r_csr_waddr;
   logic [XLEN-1:0]   r_csr_wdata;
   logic              r_flush;
   logic              r_redirect_v;
   logic [XLEN-1:0]   r_redirect_pc;
   logic [1:0]        r_priv;
   logic              r_busy;
   logic [XLEN-1:0]   r_cause;
   logic [XLEN-1:0]   r_tval;
   logic [XLEN-1:0]   r_mepc;
   logic [1:0]        r_saved_priv;

   logic [XLEN-1:0]   w_target_pc;
   logic [XLEN-1:0]   w_trap_mstatus;
   logic [XLEN-1:0]   w_mret_mstatus;

   // Only MIE, MPIE and MPP change; every other mstatus bit is written back as read.
   always_comb begin
      w_trap_mstatus = bus.MSTATUS;
      w_trap_mstatus[MSTATUS_MPIE] = bus.MSTATUS[MSTATUS_MIE];
      w_trap_mstatus[MSTATUS_MIE]  = 1'b0;
      w_trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = r_saved_priv;

      w_mret_mstatus = bus.MSTATUS;
      w_mret_mstatus[MSTATUS_MIE]  = bus.MSTATUS[MSTATUS_MPIE];
      w_mret_mstatus[MSTATUS_MPIE] = 1'b1;
      w_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
   end

   trap_target_calc #(.XLEN(XLEN)) u_target (
      .i_mtvec (bus.MTVEC),
      .i_cause (r_cause),
      .o_pc    (w_target_pc)
   );

   // Each state's CSR write is registered on entry, so outputs in a state show that state's write.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= IDLE;
         r_csr_we      <= 1'b0;
         r_csr_waddr   <= '0;
         r_csr_wdata   <= '0;
         r_flush       <= 1'b0;
         r_redirect_v  <= 1'b0;
         r_redirect_pc <= '0;
         r_priv        <= PRIV_M;
         r_busy        <= 1'b0;
         r_cause       <= '0;
         r_tval        <= '0;
         r_mepc        <= '0;
         r_saved_priv  <= PRIV_M;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         r_csr_we     <= 1'b0;
         r_redirect_v <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.TRAP_REQ) begin
                  r_cause      <= bus.TRAP_CAUSE;
                  r_tval       <= bus.TRAP_TVAL;
                  r_saved_priv <= r_priv;
                  r_csr_we     <= 1'b1;
                  r_csr_waddr  <= CSR_AW'(CSR_MEPC);
                  r_csr_wdata  <= bus.TRAP_EPC;
                  r_flush      <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= T_EPC;
               end else if (bus.MRET_REQ) begin
                  r_mepc       <= bus.MEPC;
                  r_saved_priv <= bus.MSTATUS[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                  r_csr_we     <= 1'b1;
                  r_csr_waddr  <= CSR_AW'(CSR_MSTATUS);
                  r_csr_wdata  <= w_mret_mstatus;
                  r_flush      <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= M_STAT;
               end else if (bus.CSR_INSN_WE) begin
                  r_csr_we    <= 1'b1;
                  r_csr_waddr <= bus.CSR_INSN_ADDR;
                  r_csr_wdata <= bus.CSR_INSN_DATA;
               end
            end
            T_EPC: begin
               r_csr_we    <= 1'b1;
               r_csr_waddr <= CSR_AW'(CSR_MCAUSE);
               r_csr_wdata <= r_cause;
               r_state     <= T_CAUSE;
            end
            T_CAUSE: begin
               r_csr_we    <= 1'b1;
               r_csr_waddr <= CSR_AW'(CSR_MTVAL);
               r_csr_wdata <= r_tval;
               r_state     <= T_TVAL;
            end
            T_TVAL: begin
               r_csr_we    <= 1'b1;
               r_csr_waddr <= CSR_AW'(CSR_MSTATUS);
               r_csr_wdata <= w_trap_mstatus;
               r_state     <= T_STAT;
            end
            T_STAT: begin
               r_priv        <= PRIV_M;
               r_redirect_v  <= 1'b1;
               r_redirect_pc <= w_target_pc;
               r_state       <= REDIR;
            end
            M_STAT: begin
               r_priv        <= r_saved_priv;
               r_redirect_v  <= 1'b1;
               r_redirect_pc <= r_mepc;
               r_state       <= REDIR;
            end
            REDIR: begin
               r_flush <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.CSR_WE      = r_csr_we;
   assign bus.CSR_WADDR   = r_csr_waddr;
   assign bus.CSR_WDATA   = r_csr_wdata;
   assign bus.FLUSH       = r_flush;
   assign bus.REDIRECT_V  = r_redirect_v;
   assign bus.REDIRECT_PC = r_redirect_pc;
   assign bus.PRIV        = r_priv;
   assign bus.BUSY        = r_busy;

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Directed plus randomized bench for trap_csr_sequencer; expected behaviour comes from a
// transaction-level model (expected write lists, redirect target, privilege) kept here.
module tb_trap_csr_sequencer;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   logic [1:0] model_priv;

   trap_csr_sequencer_if #(.XLEN(64), .CSR_AW(12)) bus ();

   trap_csr_sequencer dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "time limit expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_target(input logic [63:0] mtvec, input logic [63:0] cause);
      logic [63:0] base;
      base = mtvec & ~64'h3;
`ifdef TRAP_VECTORED_EN
      if ((mtvec & 64'h3) == 64'h1 && cause[63])
         return base + 4 * (cause & 64'h3F);
`endif
      return base;
   endfunction

   task automatic clear_reqs();
      bus.TRAP_REQ    = 1'b0;
      bus.MRET_REQ    = 1'b0;
      bus.CSR_INSN_WE = 1'b0;
   endtask

   task automatic drive_noise(input bit noise);
      bus.TRAP_REQ      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.MRET_REQ      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.CSR_INSN_WE   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.TRAP_CAUSE    = {$urandom, $urandom};
      bus.TRAP_EPC      = {$urandom, $urandom};
      bus.TRAP_TVAL     = {$urandom, $urandom};
      bus.CSR_INSN_ADDR = 12'($urandom);
      bus.CSR_INSN_DATA = {$urandom, $urandom};
   endtask

   task automatic check_idle(input string tag, input logic [63:0] exp_pc);
      check({tag, " idle we"},    64'(bus.CSR_WE),      64'd0);
      check({tag, " idle busy"},  64'(bus.BUSY),        64'd0);
      check({tag, " idle flush"}, 64'(bus.FLUSH),       64'd0);
      check({tag, " idle rv"},    64'(bus.REDIRECT_V),  64'd0);
      check({tag, " idle pc"},    bus.REDIRECT_PC,      exp_pc);
      check({tag, " idle priv"},  64'(bus.PRIV),        64'(model_priv));
   endtask

   task automatic do_insn(input string tag, input logic [11:0] addr, input logic [63:0] data);
      bus.CSR_INSN_WE   = 1'b1;
      bus.CSR_INSN_ADDR = addr;
      bus.CSR_INSN_DATA = data;
      tick();
      clear_reqs();
      check({tag, " we"},    64'(bus.CSR_WE),    64'd1);
      check({tag, " addr"},  64'(bus.CSR_WADDR), 64'(addr));
      check({tag, " data"},  bus.CSR_WDATA,      data);
      check({tag, " busy"},  64'(bus.BUSY),      64'd0);
      check({tag, " flush"}, 64'(bus.FLUSH),     64'd0);
      tick();
      check({tag, " we drop"}, 64'(bus.CSR_WE), 64'd0);
   endtask

   task automatic do_trap(input string tag, input logic [63:0] cause, input logic [63:0] epc,
                          input logic [63:0] tval, input logic [63:0] ms, input logic [63:0] mtvec,
                          input bit noise);
      logic [63:0] exp_ms;
      logic [63:0] exp_pc;
      logic [11:0] exp_addr[4];
      logic [63:0] exp_data[4];
      exp_ms   = (ms & ~64'h1888) | (((ms >> 3) & 64'h1) << 7) | (64'(model_priv) << 11);
      exp_pc   = model_target(mtvec, cause);
      exp_addr = '{12'h341, 12'h342, 12'h343, 12'h300};
      exp_data = '{epc, cause, tval, exp_ms};
      bus.TRAP_REQ      = 1'b1;
      bus.TRAP_CAUSE    = cause;
      bus.TRAP_EPC      = epc;
      bus.TRAP_TVAL     = tval;
      bus.MSTATUS       = ms;
      bus.MTVEC         = mtvec;
      bus.MRET_REQ      = noise;
      bus.CSR_INSN_WE   = noise;
      bus.CSR_INSN_ADDR = 12'h340;
      bus.CSR_INSN_DATA = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
         tick();
         drive_noise(noise);
         check($sformatf("%s wr%0d we", tag, k),    64'(bus.CSR_WE),     64'd1);
         check($sformatf("%s wr%0d addr", tag, k),  64'(bus.CSR_WADDR),  64'(exp_addr[k]));
         check($sformatf("%s wr%0d data", tag, k),  bus.CSR_WDATA,       exp_data[k]);
         check($sformatf("%s wr%0d busy", tag, k),  64'(bus.BUSY),       64'd1);
         check($sformatf("%s wr%0d flush", tag, k), 64'(bus.FLUSH),      64'd1);
         check($sformatf("%s wr%0d rv", tag, k),    64'(bus.REDIRECT_V), 64'd0);
      end
      model_priv = 2'b11;
      tick();
      check({tag, " redir v"},     64'(bus.REDIRECT_V), 64'd1);
      check({tag, " redir pc"},    bus.REDIRECT_PC,     exp_pc);
      check({tag, " redir priv"},  64'(bus.PRIV),       64'(model_priv));
      check({tag, " redir we"},    64'(bus.CSR_WE),     64'd0);
      check({tag, " redir flush"}, 64'(bus.FLUSH),      64'd1);
      check({tag, " redir busy"},  64'(bus.BUSY),       64'd1);
      tick();
      clear_reqs();
      check_idle(tag, exp_pc);
   endtask

   task automatic do_mret(input string tag, input logic [63:0] mepc, input logic [63:0] ms,
                          input bit noise);
      logic [63:0] exp_ms;
      exp_ms = (ms & ~64'h1888) | (((ms >> 7) & 64'h1) << 3) | 64'h80;
      bus.MRET_REQ      = 1'b1;
      bus.MEPC          = mepc;
      bus.MSTATUS       = ms;
      bus.CSR_INSN_WE   = noise;
      bus.CSR_INSN_ADDR = 12'h340;
      bus.CSR_INSN_DATA = {$urandom, $urandom};
      tick();
      drive_noise(noise);
      check({tag, " we"},    64'(bus.CSR_WE),    64'd1);
      check({tag, " addr"},  64'(bus.CSR_WADDR), 64'h300);
      check({tag, " data"},  bus.CSR_WDATA,      exp_ms);
      check({tag, " busy"},  64'(bus.BUSY),      64'd1);
      check({tag, " flush"}, 64'(bus.FLUSH),     64'd1);
      model_priv = 2'((ms >> 11) & 64'h3);
      tick();
      check({tag, " redir v"},    64'(bus.REDIRECT_V), 64'd1);
      check({tag, " redir pc"},   bus.REDIRECT_PC,     mepc);
      check({tag, " redir priv"}, 64'(bus.PRIV),       64'(model_priv));
      check({tag, " redir we"},   64'(bus.CSR_WE),     64'd0);
      tick();
      clear_reqs();
      check_idle(tag, mepc);
   endtask

   initial begin
      logic [63:0] r_cause, r_mtvec;
      int          op;
      clk = 1'b0;
      rst = 1'b1;
      n_cmp = 0;
      n_fail = 0;
      model_priv = 2'b11;
      clear_reqs();
      bus.TRAP_CAUSE = '0; bus.TRAP_EPC = '0; bus.TRAP_TVAL = '0;
      bus.CSR_INSN_ADDR = '0; bus.CSR_INSN_DATA = '0;
      bus.MTVEC = '0; bus.MEPC = '0; bus.MSTATUS = '0;
      #2;
      check("reset we",    64'(bus.CSR_WE),     64'd0);
      check("reset waddr", 64'(bus.CSR_WADDR),  64'd0);
      check("reset wdata", bus.CSR_WDATA,       64'd0);
      check("reset flush", 64'(bus.FLUSH),      64'd0);
      check("reset rv",    64'(bus.REDIRECT_V), 64'd0);
      check("reset pc",    bus.REDIRECT_PC,     64'd0);
      check("reset priv",  64'(bus.PRIV),       64'd3);
      check("reset busy",  64'(bus.BUSY),       64'd0);
      #10 rst = 1'b0;
      tick();

      do_insn("t1", 12'h340, 64'hDEAD);
      do_trap("t2", 64'd2, 64'h8000_0100, 64'h13, 64'h8, 64'h8000_0000, 1'b0);
      do_mret("t3", 64'h8000_0104, 64'h80, 1'b0);
      do_trap("t4", 64'd5, 64'h8000_0200, 64'h44, 64'hA, 64'h8000_0000, 1'b1);
      do_trap("t5 vec irq", 64'h8000_0000_0000_0007, 64'h100, 64'h0, 64'h88, 64'h8000_0001, 1'b0);
      do_trap("t5 vec exc", 64'd2, 64'h104, 64'h0, 64'h88, 64'h8000_0001, 1'b0);
      do_trap("t5 direct irq", 64'h8000_0000_0000_0007, 64'h108, 64'h0, 64'h88, 64'h8000_0000, 1'b0);

      // Reset while the mcause write is on the port.
      bus.TRAP_REQ = 1'b1;
      bus.TRAP_CAUSE = 64'd4; bus.TRAP_EPC = 64'h300; bus.TRAP_TVAL = 64'h1;
      bus.MTVEC = 64'h8000_0000; bus.MSTATUS = 64'h8;
      tick();
      clear_reqs();
      tick();
      check("t6 pre addr", 64'(bus.CSR_WADDR), 64'h342);
      rst = 1'b1;
      #1;
      check("t6 we",    64'(bus.CSR_WE),     64'd0);
      check("t6 waddr", 64'(bus.CSR_WADDR),  64'd0);
      check("t6 wdata", bus.CSR_WDATA,       64'd0);
      check("t6 flush", 64'(bus.FLUSH),      64'd0);
      check("t6 rv",    64'(bus.REDIRECT_V), 64'd0);
      check("t6 pc",    bus.REDIRECT_PC,     64'd0);
      check("t6 priv",  64'(bus.PRIV),       64'd3);
      check("t6 busy",  64'(bus.BUSY),       64'd0);
      #2 rst = 1'b0;
      model_priv = 2'b11;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("t6 quiet%0d rv", k), 64'(bus.REDIRECT_V), 64'd0);
         check($sformatf("t6 quiet%0d we", k), 64'(bus.CSR_WE),     64'd0);
      end
      do_trap("t6 after", 64'd11, 64'h400, 64'h0, 64'h0, 64'h8000_0040, 1'b0);

      for (int i = 0; i < 30; i++) begin
         op = $urandom_range(0, 2);
         r_cause = {$urandom, $urandom};
         r_mtvec = {$urandom, $urandom};
         r_mtvec[1:0] = $urandom_range(0, 1) ? 2'b01 : 2'($urandom_range(0, 3));
         bus.MTVEC = r_mtvec;
         if (op == 0)
            do_insn($sformatf("rnd%0d insn", i), 12'($urandom), {$urandom, $urandom});
         else if (op == 1)
            do_trap($sformatf("rnd%0d trap", i), r_cause, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, r_mtvec, 1'($urandom_range(0, 1)));
         else
            do_mret($sformatf("rnd%0d mret", i), {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
